// File: rtl/v_pkg.sv
// Shared opcode constants, reduction match values and issue-state encoding
// for the vector issue queue.
package v_pkg;

    localparam logic [6:0] OPC_OPV       = 7'h57;
    localparam logic [6:0] OPC_VLOAD     = 7'h07;
    localparam logic [6:0] OPC_VSTORE    = 7'h27;
    localparam logic [2:0] RED_FUNCT3    = 3'b010;
    localparam logic [2:0] RED_FUNCT6_HI = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2
    } issue_state_e;

    function automatic logic is_vector_op(input logic [31:0] instr);
        return (instr[6:0] == OPC_OPV) || (instr[6:0] == OPC_VLOAD) ||
               (instr[6:0] == OPC_VSTORE);
    endfunction

    // Reductions write a scalar back, so the pipe must stall until the unit reports done.
    function automatic logic is_reduction(input logic [31:0] instr);
        return (instr[6:0] == OPC_OPV) && (instr[14:12] == RED_FUNCT3) &&
               (instr[31:29] == RED_FUNCT6_HI);
    endfunction

endpackage

// File: rtl/v_instr_fifo.sv
// Instruction FIFO for the issue queue: power-of-two depth, wrapping
// pointers, synchronous clear.
module v_instr_fifo
    import v_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     clr_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [31:0]              wdata_i,
    output logic [31:0]              rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [31:0]   mem_q [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o && !clr_i;
    assign do_pop  = pop_i && !empty_o && !clr_i;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/v_issue_queue.sv
// Vector issue queue: filters vector ops from the base core, queues them and
// issues one per cycle, stalling behind reductions until done or timeout.
//
// state        | meaning
// ST_IDLE      | nothing on the output; pop the head when the FIFO has one
// ST_ISSUE     | op_instr_base valid for this cycle; decide next by the issued word
// ST_WAIT_DONE | reduction outstanding; count cycles until red_done or timeout
module v_issue_queue
    import v_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [31:0] base_instr,
    input  logic        base_valid,
    output logic        base_ready,
    input  logic        flush,
    input  logic        red_done,
    output logic [31:0] op_instr_base,
    output logic        issue_valid,
    output logic        busy,
    output logic        err_timeout
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMR_TC = TW'(TIMEOUT - 1);

    issue_state_e          state_q, state_d;
    logic [31:0]           op_q, op_d;
    logic [TW-1:0]         tmr_q, tmr_d;
    logic                  err_q, err_d;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic [31:0]           fifo_rdata;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;

    // Scalar opcodes complete the handshake but are dropped here.
    assign base_ready = !fifo_full;
    assign fifo_push  = base_valid && base_ready && is_vector_op(base_instr) && !flush;

    v_instr_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk     (clk),
        .nrst    (nrst),
        .clr_i   (flush),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i (base_instr),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            tmr_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            tmr_q   <= tmr_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        tmr_d    = tmr_q;
        err_d    = err_q;
        fifo_pop = 1'b0;
        if (flush) begin
            state_d = ST_IDLE;
            op_d    = '0;
            tmr_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        op_d     = fifo_rdata;
                        state_d  = ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (is_reduction(op_q)) begin
                        op_d    = '0;
                        state_d = ST_WAIT_DONE;
                    end else if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        op_d     = fifo_rdata;
                    end else begin
                        op_d    = '0;
                        state_d = ST_IDLE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (red_done) begin
                        tmr_d   = '0;
                        state_d = ST_IDLE;
                    end else if (tmr_q == TMR_TC) begin
                        err_d   = 1'b1;
                        tmr_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        tmr_d = tmr_q + TW'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    op_d    = '0;
                    tmr_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        issue_valid = (state_q == ST_ISSUE);
        busy        = (fifo_count != '0) || (state_q != ST_IDLE);
    end

    assign op_instr_base = op_q;
    assign err_timeout   = err_q;

endmodule

// File: tb/tb_v_issue_queue.sv
// Scoreboard bench for v_issue_queue: accepted vector words queue up as
// expected issues; directed timing scenarios plus a randomized traffic run.
module tb_v_issue_queue;

    localparam logic [31:0] VADD  = 32'h022081D7;
    localparam logic [31:0] VRED  = 32'h0220A1D7;
    localparam logic [31:0] ADDI  = 32'h00100093;

    logic        clk = 1'b0;
    logic        nrst = 1'b1;
    logic [31:0] base_instr = '0;
    logic        base_valid = 1'b0;
    logic        flush = 1'b0;
    logic        red_done = 1'b0;
    logic        base_ready;
    logic [31:0] op_instr_base;
    logic        issue_valid;
    logic        busy;
    logic        err_timeout;

    int          n_chk = 0;
    int          n_pass = 0;
    int          n_issue = 0;
    int          ni;
    logic [31:0] exp_q[$];
    logic [31:0] rw;
    logic        acc;

    logic [31:0] w4[4] = '{32'h022081D7, 32'h02310257, 32'h024182D7, 32'h02520357};
    logic [31:0] wf[5] = '{32'h02008007, 32'h02010027, 32'h022081D7, 32'h0640C057, 32'h00A28207};

    v_issue_queue #(.DEPTH(4), .TIMEOUT(64)) dut (
        .clk           (clk),
        .nrst          (nrst),
        .base_instr    (base_instr),
        .base_valid    (base_valid),
        .base_ready    (base_ready),
        .flush         (flush),
        .red_done      (red_done),
        .op_instr_base (op_instr_base),
        .issue_valid   (issue_valid),
        .busy          (busy),
        .err_timeout   (err_timeout)
    );

    always #5 clk = ~clk;

    function automatic bit ref_is_vec(input logic [31:0] w);
        logic [6:0] o;
        o = w[6:0];
        return (o == 7'h57) || (o == 7'h07) || (o == 7'h27);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, req);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int max, input string name);
        int t;
        t = 0;
        while (busy && t < max) begin
            cyc();
            t++;
        end
        chk(name, busy, 0);
    endtask

    // Expected issue stream: every accepted vector word, in acceptance order.
    always @(posedge clk) begin
        if (!nrst || flush) exp_q.delete();
        else if (base_valid && base_ready && ref_is_vec(base_instr)) exp_q.push_back(base_instr);
    end

    always @(negedge clk) begin
        if (nrst) begin
            if (issue_valid) begin
                n_issue++;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_issue: got %h want none", op_instr_base);
                end else begin
                    chk("issue_order", op_instr_base, exp_q.pop_front());
                end
            end else begin
                chk("idle_op_zero", op_instr_base, 32'h0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        #2 nrst = 1'b0;
        #1;
        chk("rst_ready", base_ready, 1);
        chk("rst_valid", issue_valid, 0);
        chk("rst_op", op_instr_base, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_timeout, 0);
        cyc();
        cyc();
        nrst = 1'b1;

        // single issue, two-edge latency
        base_instr = VADD; base_valid = 1'b1;
        cyc();
        base_valid = 1'b0;
        chk("single_lat1", issue_valid, 0);
        cyc();
        chk("single_valid", issue_valid, 1);
        chk("single_word", op_instr_base, VADD);
        cyc();
        chk("single_end", issue_valid, 0);
        chk("single_op0", op_instr_base, 0);
        chk("single_busy", busy, 0);

        // back-to-back issue
        for (int c = 0; c < 7; c++) begin
            if (c < 4) begin
                base_instr = w4[c]; base_valid = 1'b1;
                chk("b2b_ready", base_ready, 1);
            end else base_valid = 1'b0;
            cyc();
            if (c >= 1 && c <= 4) begin
                chk("b2b_valid", issue_valid, 1);
                chk("b2b_word", op_instr_base, w4[c-1]);
            end
            if (c == 5) chk("b2b_end", issue_valid, 0);
            if (c == 6) chk("b2b_busy", busy, 0);
        end

        // reduction stall released by red_done
        base_instr = VRED; base_valid = 1'b1;
        cyc();
        base_instr = VADD;
        cyc();
        base_valid = 1'b0;
        chk("red_issue", op_instr_base, VRED);
        cyc();
        chk("red_wait", issue_valid, 0);
        repeat (4) begin
            cyc();
            chk("stall_hold", issue_valid, 0);
            chk("stall_busy", busy, 1);
        end
        red_done = 1'b1;
        cyc();
        red_done = 1'b0;
        chk("done_idle", issue_valid, 0);
        cyc();
        chk("done_valid", issue_valid, 1);
        chk("done_word", op_instr_base, VADD);
        cyc();
        cyc();
        chk("done_busy", busy, 0);

        // timeout after 64 WAIT_DONE cycles
        base_instr = VRED; base_valid = 1'b1;
        cyc();
        base_instr = VADD;
        cyc();
        base_valid = 1'b0;
        cyc();
        for (int k = 1; k <= 63; k++) cyc();
        chk("to_early", err_timeout, 0);
        cyc();
        chk("to_err", err_timeout, 1);
        chk("to_idle", issue_valid, 0);
        cyc();
        chk("to_next_valid", issue_valid, 1);
        chk("to_next_word", op_instr_base, VADD);
        repeat (3) cyc();
        chk("to_sticky", err_timeout, 1);

        // full FIFO and pointer wrap
        base_instr = VRED; base_valid = 1'b1;
        cyc();
        base_valid = 1'b0;
        cyc();
        cyc();
        for (int c = 0; c < 4; c++) begin
            base_instr = wf[c]; base_valid = 1'b1;
            chk("full_ready", base_ready, 1);
            cyc();
        end
        base_instr = wf[4];
        repeat (3) begin
            chk("full_block", base_ready, 0);
            cyc();
        end
        red_done = 1'b1;
        cyc();
        red_done = 1'b0;
        acc = 1'b0;
        for (int t = 0; t < 10 && !acc; t++) begin
            if (base_ready) acc = 1'b1;
            cyc();
        end
        base_valid = 1'b0;
        chk("full_accept5", acc, 1);
        wait_idle(40, "full_drain");
        chk("full_all_issued", exp_q.size(), 0);

        // scalar filter
        base_instr = ADDI; base_valid = 1'b1;
        cyc();
        base_valid = 1'b0;
        chk("filter_busy", busy, 0);
        ni = n_issue;
        repeat (5) cyc();
        chk("filter_none", n_issue - ni, 0);

        // flush in WAIT_DONE with two queued words
        base_instr = VRED; base_valid = 1'b1;
        cyc();
        base_valid = 1'b0;
        cyc();
        cyc();
        base_instr = wf[0]; base_valid = 1'b1;
        cyc();
        base_instr = wf[1];
        cyc();
        base_valid = 1'b0;
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("flush_busy", busy, 0);
        chk("flush_op", op_instr_base, 0);
        chk("flush_valid", issue_valid, 0);
        ni = n_issue;
        repeat (10) cyc();
        chk("flush_none", n_issue - ni, 0);
        chk("flush_err_sticky", err_timeout, 1);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            int k;
            k  = $urandom_range(0, 9);
            rw = $urandom;
            if (k <= 3) begin
                rw[6:0] = 7'h57;
                if (rw[31:29] == 3'b000 && rw[14:12] == 3'b010) rw[12] = 1'b1;
            end else if (k == 4) begin
                rw[6:0] = 7'h57; rw[14:12] = 3'b010; rw[31:29] = 3'b000;
            end else if (k == 5) rw[6:0] = 7'h07;
            else if (k == 6) rw[6:0] = 7'h27;
            else rw[6:0] = ($urandom_range(0, 1) == 0) ? 7'h13 : 7'h33;
            base_instr = rw;
            base_valid = ($urandom_range(0, 1) == 1);
            red_done   = ($urandom_range(0, 7) == 0);
            flush      = ($urandom_range(0, 60) == 0);
            cyc();
        end
        base_valid = 1'b0;
        flush = 1'b0;
        red_done = 1'b1;
        wait_idle(60, "rand_drain");
        red_done = 1'b0;
        cyc();
        chk("rand_all_issued", exp_q.size(), 0);

        // reset mid-WAIT_DONE discards everything
        base_instr = VRED; base_valid = 1'b1;
        cyc();
        base_valid = 1'b0;
        cyc();
        cyc();
        base_instr = VADD; base_valid = 1'b1;
        cyc();
        base_valid = 1'b0;
        #2 nrst = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_err", err_timeout, 0);
        chk("mid_rst_op", op_instr_base, 0);
        chk("mid_rst_valid", issue_valid, 0);
        cyc();
        cyc();
        nrst = 1'b1;
        ni = n_issue;
        repeat (8) cyc();
        chk("mid_rst_none", n_issue - ni, 0);
        chk("mid_rst_idle", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/v_issue_queue.md
V_ISSUE_QUEUE -- requirements
Module: v_issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4: instruction FIFO entries, power of two, range 2..16.
REQ-002 SHALL have parameter TIMEOUT, default 64: maximum WAIT_DONE cycles before abort.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port nrst, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port base_instr, input, 32: instruction offered by the base processor.
REQ-006 SHALL have port base_valid, input, 1: base_instr is valid this cycle.
REQ-007 SHALL have port base_ready, output, 1: the queue can accept this cycle.
REQ-008 SHALL have port flush, input, 1: synchronous discard of all queued and in-flight state.
REQ-009 SHALL have port red_done, input, 1: completion pulse from the reduction unit.
REQ-010 SHALL have port op_instr_base, output, 32: registered instruction to the coprocessor; 32'h0 means no operation.
REQ-011 SHALL have port issue_valid, output, 1: op_instr_base carries an instruction this cycle.
REQ-012 SHALL have port busy, output, 1: FIFO non-empty or state not IDLE.
REQ-013 SHALL have port err_timeout, output, 1: sticky flag, cleared only by reset.

Function
REQ-014 SHALL assert base_ready combinationally when count < DEPTH; a pop in the same cycle does not raise base_ready.
REQ-015 SHALL enqueue base_instr when base_valid && base_ready and opcode bits [6:0] are 7'h57 (OP-V), 7'h07 or 7'h27 (vector load/store); other opcodes are accepted and discarded.
REQ-016 SHALL implement the FIFO with write and read pointers that wrap modulo DEPTH and a count of width clog2(DEPTH)+1; simultaneous push and pop leave count unchanged.
REQ-017 SHALL use a state machine with states IDLE, ISSUE and WAIT_DONE.
REQ-018 IDLE: op_instr_base = 0 and issue_valid = 0; if the FIFO is non-empty, pop the head into the output register and go to ISSUE.
REQ-019 ISSUE: issue_valid = 1 for exactly one cycle with op_instr_base = the issued word; classify the issued word as follows.
REQ-020 ISSUE, reduction word (opcode 7'h57, funct3 3'b010, funct6[5:3] = 3'b000): clear the output register and go to WAIT_DONE.
REQ-021 ISSUE, non-reduction word with FIFO non-empty: pop the next head and stay in ISSUE, giving one issue per cycle.
REQ-022 ISSUE, non-reduction word with FIFO empty: clear the output register and go to IDLE.
REQ-023 WAIT_DONE: op_instr_base = 0; increment a cycle counter each cycle.
REQ-024 WAIT_DONE: on red_done go to IDLE and clear the counter.
REQ-025 WAIT_DONE: when the counter reaches TIMEOUT-1 without red_done, set err_timeout, clear the counter and go to IDLE.
REQ-026 SHALL ignore red_done in every state other than WAIT_DONE.
REQ-027 SHALL make a word accepted at edge N with empty FIFO and state IDLE appear on op_instr_base after edge N+1 (latency 2 edges).
REQ-028 flush SHALL empty the FIFO, zero op_instr_base and issue_valid, clear the counter and enter IDLE at the next edge; flush overrides a same-cycle push, pop or red_done.
REQ-029 SHALL let an enqueue into a full FIFO have no effect, because base_ready is low.

Reset
REQ-030 On nrst low SHALL immediately force: state IDLE, pointers, count and counter 0, op_instr_base 32'h0, issue_valid 0, busy 0, err_timeout 0.
REQ-031 Reset asserted mid-WAIT_DONE or mid-ISSUE SHALL discard the in-flight instruction with no issue after release.

Structure
REQ-032 The OP-V, vector-load and vector-store opcode constants, the reduction funct3/funct6 match values and the issue-state enum SHALL live in v_pkg.
REQ-033 Storage SHALL be a sub-module v_instr_fifo (push, pop, data, count, full, empty); the FSM, counter and output register live in v_issue_queue.

Verification
REQ-034 Single issue: after reset, push vadd.vv 32'h022081D7 once -> op_instr_base = 32'h022081D7 with issue_valid = 1 for one cycle, 2 edges after acceptance, then 32'h0; busy returns 0.
REQ-035 Back-to-back: push 4 vadd words in consecutive cycles -> base_ready stays 1; issued in order on 4 consecutive cycles; count peaks at or below 4.
REQ-036 Reduction stall: push vredsum.vs 32'h0220A1D7 then vadd 32'h022081D7 -> vadd withheld until red_done pulses 5 cycles later, then issued the cycle after the return to IDLE.
REQ-037 Timeout: push 32'h0220A1D7 and never pulse red_done -> err_timeout rises after 64 WAIT_DONE cycles and stays 1; the next queued word issues normally.
REQ-038 Full and wrap: hold the FIFO in WAIT_DONE and push 5 words -> base_ready drops after 4; the 5th is held by the base processor; after red_done all issue in order across the pointer wrap.
REQ-039 Flush and filter: push a scalar addi 32'h00100093 -> never issued; flush in WAIT_DONE with 2 queued words -> next cycle busy = 0, op_instr_base = 0, and nothing issues afterward.
